// File: rtl/uart16550_seq_if.sv
// Register-port bundle between the uart16550_seq sequencer (master) and the
// uart_regs 16550 core (slave).
interface uart16550_seq_if;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_we;
  logic       reg_re;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/uart16550_seq.sv
// Autonomous register-port sequencer for the uart_regs 16550 core: init, then TX/RX
// byte streaming with LSR polling. Optional statistics counters: UART16550_SEQ_STATS_EN.
module uart16550_seq #(
  parameter logic [15:0] DIVISOR       = 16'd27,
  parameter logic [7:0]  LCR_VAL       = 8'h03,
  parameter logic [7:0]  FCR_VAL       = 8'h07,
  parameter int          TX_FIFO_DEPTH = 16
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  uart16550_seq_if.master regs,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [7:0]      rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  input  logic            cfg_restart,
  output logic            init_done,
  output logic [3:0]      lsr_err
`ifdef UART16550_SEQ_STATS_EN
  ,
  output logic [15:0]     tx_count,
  output logic [15:0]     rx_count,
  output logic [7:0]      ovr_count
`endif
);

  localparam logic [3:0] S_I0   = 4'd0;
  localparam logic [3:0] S_I1   = 4'd1;
  localparam logic [3:0] S_I2   = 4'd2;
  localparam logic [3:0] S_I3   = 4'd3;
  localparam logic [3:0] S_I4   = 4'd4;
  localparam logic [3:0] S_I5   = 4'd5;
  localparam logic [3:0] S_IDLE = 4'd6;
  localparam logic [3:0] S_TXWR = 4'd7;
  localparam logic [3:0] S_POLL = 4'd8;
  localparam logic [3:0] S_PCAP = 4'd9;
  localparam logic [3:0] S_RXRD = 4'd10;
  localparam logic [3:0] S_RCAP = 4'd11;

  localparam logic [4:0] CREDIT_FULL = 5'(TX_FIFO_DEPTH);

  logic [3:0] state_r;
  logic [3:0] next_state_s;
  logic       armed_r;
  logic [4:0] credit_r;
  logic       prefer_rx_r;
  logic       restart_pend_r;
  logic       we_s;
  logic       re_s;
  logic [2:0] addr_s;
  logic [7:0] wdata_s;
  logic       tx_ready_s;

  // Next-state selection; state_r names the action visible on the port this cycle.
  always_comb begin
    next_state_s = state_r;
    if (!armed_r) begin
      next_state_s = S_I0;
    end else begin
      case (state_r)
        S_I0:   next_state_s = S_I1;
        S_I1:   next_state_s = S_I2;
        S_I2:   next_state_s = S_I3;
        S_I3:   next_state_s = S_I4;
        S_I4:   next_state_s = S_I5;
        S_I5:   next_state_s = S_IDLE;
        S_IDLE: begin
          if (restart_pend_r) begin
            next_state_s = S_I0;
          end else if (tx_valid && (credit_r != 5'd0) && !prefer_rx_r) begin
            next_state_s = S_TXWR;
          end else begin
            next_state_s = S_POLL;
          end
        end
        S_TXWR: next_state_s = S_IDLE;
        S_POLL: next_state_s = S_PCAP;
        S_PCAP: begin
          if (regs.reg_rdata[0] && !rx_valid) begin
            next_state_s = S_RXRD;
          end else begin
            next_state_s = S_IDLE;
          end
        end
        S_RXRD: next_state_s = S_RCAP;
        S_RCAP: next_state_s = S_IDLE;
        default: next_state_s = S_I0;
      endcase
    end
  end

  // Port action of the state being entered, registered at the same edge.
  always_comb begin
    we_s       = 1'b0;
    re_s       = 1'b0;
    addr_s     = 3'd0;
    wdata_s    = 8'h00;
    tx_ready_s = 1'b0;
    case (next_state_s)
      S_I0:   begin we_s = 1'b1; addr_s = 3'd3; wdata_s = 8'h80;            end
      S_I1:   begin we_s = 1'b1; addr_s = 3'd0; wdata_s = DIVISOR[7:0];     end
      S_I2:   begin we_s = 1'b1; addr_s = 3'd1; wdata_s = DIVISOR[15:8];    end
      S_I3:   begin we_s = 1'b1; addr_s = 3'd3; wdata_s = LCR_VAL;          end
      S_I4:   begin we_s = 1'b1; addr_s = 3'd2; wdata_s = FCR_VAL;          end
      S_I5:   begin we_s = 1'b1; addr_s = 3'd1; wdata_s = 8'h00;            end
      S_TXWR: begin we_s = 1'b1; addr_s = 3'd0; wdata_s = tx_data; tx_ready_s = 1'b1; end
      S_POLL: begin re_s = 1'b1; addr_s = 3'd5;                             end
      S_RXRD: begin re_s = 1'b1; addr_s = 3'd0;                             end
      default: begin we_s = 1'b0; re_s = 1'b0;                              end
    endcase
  end

  // Register-port and tx handshake outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      regs.reg_we    <= 1'b0;
      regs.reg_re    <= 1'b0;
      regs.reg_addr  <= 3'd0;
      regs.reg_wdata <= 8'h00;
      tx_ready       <= 1'b0;
    end else begin
      regs.reg_we    <= we_s;
      regs.reg_re    <= re_s;
      regs.reg_addr  <= addr_s;
      regs.reg_wdata <= wdata_s;
      tx_ready       <= tx_ready_s;
    end
  end

  // Sequencer state, THR credit, arbitration and status flags.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r        <= S_I0;
      armed_r        <= 1'b0;
      credit_r       <= 5'd0;
      prefer_rx_r    <= 1'b0;
      restart_pend_r <= 1'b0;
      init_done      <= 1'b0;
      lsr_err        <= 4'd0;
    end else begin
      state_r <= next_state_s;
      armed_r <= 1'b1;

      if (cfg_restart) begin
        restart_pend_r <= 1'b1;
      end else if (armed_r && (state_r == S_IDLE) && restart_pend_r) begin
        restart_pend_r <= 1'b0;
      end else begin
        restart_pend_r <= restart_pend_r;
      end

      if (armed_r && (state_r == S_I5)) begin
        init_done <= 1'b1;
      end else if (armed_r && (state_r == S_IDLE) && (next_state_s == S_I0)) begin
        init_done <= 1'b0;
      end else begin
        init_done <= init_done;
      end

      // A THRE=1 poll reloads the full FIFO allowance, discarding any leftover.
      if (state_r == S_I0) begin
        credit_r <= 5'd0;
      end else if ((state_r == S_PCAP) && regs.reg_rdata[5]) begin
        credit_r <= CREDIT_FULL;
      end else if ((next_state_s == S_TXWR) && (credit_r != 5'd0)) begin
        credit_r <= credit_r - 5'd1;
      end else begin
        credit_r <= credit_r;
      end

      if (next_state_s == S_TXWR) begin
        prefer_rx_r <= 1'b1;
      end else if (state_r == S_PCAP) begin
        prefer_rx_r <= 1'b0;
      end else begin
        prefer_rx_r <= prefer_rx_r;
      end

      if (state_r == S_I0) begin
        lsr_err <= 4'd0;
      end else if (state_r == S_PCAP) begin
        lsr_err <= lsr_err | regs.reg_rdata[4:1];
      end else begin
        lsr_err <= lsr_err;
      end
    end
  end

  // Single-entry receive buffer; survives a restart.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (state_r == S_RCAP) begin
      rx_data  <= regs.reg_rdata;
      rx_valid <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_data  <= rx_data;
      rx_valid <= 1'b0;
    end else begin
      rx_data  <= rx_data;
      rx_valid <= rx_valid;
    end
  end

`ifdef UART16550_SEQ_STATS_EN
  // Traffic statistics; overrun count saturates, byte counts wrap.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_count  <= 16'd0;
      rx_count  <= 16'd0;
      ovr_count <= 8'd0;
    end else if (state_r == S_I0) begin
      tx_count  <= 16'd0;
      rx_count  <= 16'd0;
      ovr_count <= 8'd0;
    end else begin
      tx_count  <= (next_state_s == S_TXWR) ? tx_count + 16'd1 : tx_count;
      rx_count  <= (state_r == S_RCAP) ? rx_count + 16'd1 : rx_count;
      ovr_count <= ((state_r == S_PCAP) && regs.reg_rdata[1] && (ovr_count != 8'hFF))
                   ? ovr_count + 8'd1 : ovr_count;
    end
  end
`endif

endmodule

// File: tb/tb_uart16550_seq.sv
// Directed self-checking bench for uart16550_seq with a small uart_regs read model.
module tb_uart16550_seq;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        cfg_restart = 1'b0;
  logic        init_done;
  logic [3:0]  lsr_err;
`ifdef UART16550_SEQ_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic [7:0]  ovr_count;
`endif

  always #5 HCLK = ~HCLK;

  uart16550_seq_if regs();

  uart16550_seq dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .regs        (regs.master),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .cfg_restart (cfg_restart),
    .init_done   (init_done),
    .lsr_err     (lsr_err)
`ifdef UART16550_SEQ_STATS_EN
    ,
    .tx_count    (tx_count),
    .rx_count    (rx_count),
    .ovr_count   (ovr_count)
`endif
  );

  // uart_regs read model: registered read data, optional one-shot LSR value.
  logic [7:0] lsr_base = 8'h00;
  logic [7:0] rbr_val  = 8'h00;
  logic [7:0] once_val = 8'h00;
  int         once_req = 0;
  int         once_ack = 0;
  int         both_cnt = 0;

  always @(posedge HCLK) begin
    if (regs.reg_re) begin
      if (regs.reg_addr == 3'd5) begin
        if (once_req != once_ack) begin
          regs.reg_rdata <= once_val;
          once_ack <= once_ack + 1;
        end else begin
          regs.reg_rdata <= lsr_base;
        end
      end else if (regs.reg_addr == 3'd0) begin
        regs.reg_rdata <= rbr_val;
      end else begin
        regs.reg_rdata <= 8'h00;
      end
    end
  end

  always @(negedge HCLK) begin
    if (regs.reg_we && regs.reg_re) both_cnt <= both_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [2:0] init_addr [6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
  logic [7:0] init_data [6] = '{8'h80, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};

  task automatic check_init(input bit skip_first);
    for (int i = 0; i < 6; i++) begin
      if (!(skip_first && i == 0)) @(negedge HCLK);
      check("init_we",      regs.reg_we,    1'b1);
      check("init_re",      regs.reg_re,    1'b0);
      check("init_addr",    regs.reg_addr,  init_addr[i]);
      check("init_wdata",   regs.reg_wdata, init_data[i]);
      check("init_done_lo", init_done,      1'b0);
      check("init_tx_rdy",  tx_ready,       1'b0);
    end
    @(negedge HCLK);
    check("init_done_hi", init_done, 1'b1);
    check("init_end_we",  regs.reg_we, 1'b0);
  endtask

  logic [7:0] tx_bytes [3] = '{8'h41, 8'h42, 8'h43};
  int  wr_n, rdy_n, bad_rdy, polls_since, no_poll_wr, rd0;
  bit  found;

  initial begin
    // Reset state
    repeat (3) @(negedge HCLK);
    check("rst_we",       regs.reg_we,    1'b0);
    check("rst_re",       regs.reg_re,    1'b0);
    check("rst_addr",     regs.reg_addr,  3'd0);
    check("rst_wdata",    regs.reg_wdata, 8'h00);
    check("rst_tx_ready", tx_ready,       1'b0);
    check("rst_rx_valid", rx_valid,       1'b0);
    check("rst_rx_data",  rx_data,        8'h00);
    check("rst_init",     init_done,      1'b0);
    check("rst_lsr_err",  lsr_err,        4'd0);
    HRESETn = 1'b1;
    check_init(1'b0);

    // Transmit three bytes with THRE set
    lsr_base = 8'h60;
    tx_data = tx_bytes[0];
    tx_valid = 1'b1;
    wr_n = 0; rdy_n = 0; bad_rdy = 0; polls_since = 0; no_poll_wr = 0;
    for (int c = 0; c < 80 && wr_n < 3; c++) begin
      @(negedge HCLK);
      if (regs.reg_re && regs.reg_addr == 3'd5) polls_since++;
      if (tx_ready) begin
        rdy_n++;
        if (!(regs.reg_we && regs.reg_addr == 3'd0)) bad_rdy++;
      end
      if (regs.reg_we && regs.reg_addr == 3'd0) begin
        check("tx_byte", regs.reg_wdata, tx_bytes[wr_n]);
        if (polls_since == 0) no_poll_wr++;
        polls_since = 0;
        wr_n++;
        @(posedge HCLK); #1;
        if (wr_n < 3) tx_data = tx_bytes[wr_n];
        else tx_valid = 1'b0;
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge HCLK);
      if (tx_ready) rdy_n++;
    end
    check("tx_writes",    wr_n,       3);
    check("tx_ready_cnt", rdy_n,      3);
    check("tx_ready_we",  bad_rdy,    0);
    check("tx_poll_gap",  no_poll_wr, 0);

    // Receive with consumer stalled, then release
    lsr_base = 8'h61;
    rbr_val = 8'h5A;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge HCLK);
      if (rx_valid) found = 1'b1;
    end
    check("rx_found", found,   1'b1);
    check("rx_data",  rx_data, 8'h5A);
    rd0 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge HCLK);
      if (regs.reg_re && regs.reg_addr == 3'd0) rd0++;
    end
    check("rx_no_read",   rd0,      0);
    check("rx_hold_vld",  rx_valid, 1'b1);
    check("rx_hold_data", rx_data,  8'h5A);
    rbr_val = 8'h7C;
    rx_ready = 1'b1;
    @(posedge HCLK); #1;
    rx_ready = 1'b0;
    @(negedge HCLK);
    check("rx_cleared", rx_valid, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge HCLK);
      if (rx_valid) found = 1'b1;
    end
    lsr_base = 8'h60;
    check("rx2_found", found,   1'b1);
    check("rx2_data",  rx_data, 8'h7C);

    // Sticky overrun error, then restart
    once_val = 8'h02;
    once_req = once_req + 1;
    for (int c = 0; c < 40 && once_ack != once_req; c++) @(negedge HCLK);
    check("err_poll_seen", once_ack, once_req);
    repeat (4) @(negedge HCLK);
    check("lsr_err_set", lsr_err, 4'b0001);
    repeat (12) @(negedge HCLK);
    check("lsr_err_sticky", lsr_err, 4'b0001);
    cfg_restart = 1'b1;
    @(posedge HCLK); #1;
    cfg_restart = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge HCLK);
      if (regs.reg_we && regs.reg_addr == 3'd3 && regs.reg_wdata == 8'h80) found = 1'b1;
    end
    check("restart_seen", found, 1'b1);
    check_init(1'b1);
    check("restart_err_clr", lsr_err,  4'd0);
    check("restart_rx_vld",  rx_valid, 1'b1);
    check("restart_rx_data", rx_data,  8'h7C);

    // Reset asserted during an RBR read
    rbr_val = 8'h33;
    lsr_base = 8'h61;
    rx_ready = 1'b1;
    @(posedge HCLK); #1;
    rx_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge HCLK);
      if (regs.reg_re && regs.reg_addr == 3'd0) found = 1'b1;
    end
    check("rxrd_seen", found, 1'b1);
    HRESETn = 1'b0;
    #1;
    check("arst_re",       regs.reg_re,   1'b0);
    check("arst_we",       regs.reg_we,   1'b0);
    check("arst_addr",     regs.reg_addr, 3'd0);
    check("arst_rx_valid", rx_valid,      1'b0);
    check("arst_rx_data",  rx_data,       8'h00);
    check("arst_init",     init_done,     1'b0);
    check("arst_tx_ready", tx_ready,      1'b0);
    check("arst_lsr_err",  lsr_err,       4'd0);
    lsr_base = 8'h00;
`ifdef UART16550_SEQ_STATS_EN
    once_val = 8'h60;
    once_req = once_req + 1;
    tx_data = 8'h80;
    tx_valid = 1'b1;
`endif
    @(negedge HCLK);
    HRESETn = 1'b1;
    check_init(1'b0);

`ifdef UART16550_SEQ_STATS_EN
    // Credit limit: one THRE poll allows exactly TX_FIFO_DEPTH writes
    check("st_tx_cnt0", tx_count, 16'd0);
    wr_n = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge HCLK);
      if (regs.reg_we && regs.reg_addr == 3'd0) begin
        check("st_byte", regs.reg_wdata, 8'(128 + wr_n));
        wr_n++;
        @(posedge HCLK); #1;
        tx_data = 8'(128 + wr_n);
      end
    end
    check("st_writes16", wr_n,     16);
    check("st_tx_cnt16", tx_count, 16'd16);
    lsr_base = 8'h60;
    for (int c = 0; c < 100 && wr_n < 20; c++) begin
      @(negedge HCLK);
      if (regs.reg_we && regs.reg_addr == 3'd0) begin
        check("st_byte", regs.reg_wdata, 8'(128 + wr_n));
        wr_n++;
        @(posedge HCLK); #1;
        if (wr_n < 20) tx_data = 8'(128 + wr_n);
        else tx_valid = 1'b0;
      end
    end
    repeat (2) @(negedge HCLK);
    check("st_writes20", wr_n,      20);
    check("st_tx_cnt20", tx_count,  16'd20);
    check("st_rx_cnt",   rx_count,  16'd0);
    check("st_ovr_cnt",  ovr_count, 8'd0);
`endif

    check("strobe_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
